ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Instruction prefetch queue between the Raisin64 pipeline fetch stage and the instruction memory (ram instance, imem).
- Holds the fetch PC and issues sequential 64-bit word requests on the imem address port.
- Buffers returned words with their PCs in a FIFO and presents them to the pipeline over a valid/ready handshake.
- Handles pipeline redirects by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- MAX_OUTSTANDING, 2, maximum issued-but-unreturned imem requests; 1..DEPTH.
- RESET_PC, 64'h0, fetch PC after reset; 8-byte aligned.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  64  new fetch PC; bits [2:0] ignored (treated as 0).
- imem_addr  out  64  request byte address, always 8-byte aligned.
- imem_addr_valid  out  1  request strobe; the memory accepts every cycle it is high.
- imem_data  in  64  returned instruction word.
- imem_data_valid  in  1  imem_data holds the oldest outstanding response; responses return in order.
- inst_data  out  64  head-of-queue instruction word.
- inst_pc  out  64  PC of inst_data.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  pipeline accepts head this cycle.
- occupancy  out  $clog2(DEPTH)+1  current FIFO entry count.

Behaviour:
- Interface fixed: one clock, clk; reset rst is asynchronous, active-high.
- Reset values:
  - imem_addr_valid=0, imem_addr=RESET_PC
  - inst_valid=0, inst_data=0, inst_pc=0, occupancy=0
  - internal fetch PC=RESET_PC, outstanding=0, discard=0, state=FETCH.
- Reset mid-operation drops all entries and in-flight accounting immediately; responses arriving after rst deasserts and before any new request are ignored.
- FSM has two states:
  - FETCH: imem_addr_valid = (occupancy + outstanding < DEPTH) && (outstanding < MAX_OUTSTANDING) && !redirect. imem_addr = fetch PC. On an issue, fetch PC += 8 (wraps modulo 2^64) and outstanding increments.
  - FLUSH: entered when redirect is sampled while outstanding > 0. Takes discard = outstanding minus any response arriving that cycle, then discards that many responses and issues no requests. Returns to FETCH when discard reaches 0; the first new request is issued in that same cycle.
- Redirect in either state, same edge:
  - FIFO emptied; fetch PC = redirect_pc & ~7.
  - inst_valid low the next cycle.
  - If outstanding is 0, or the only outstanding response arrives this cycle, stay in or return to FETCH and issue from redirect_pc on the next cycle.
  - Redirect during FLUSH adds any newly issued requests to discard; none are issued in FLUSH, so discard is unchanged.
- Response path:
  - In FETCH, imem_data_valid writes {imem_data, PC} to the FIFO tail and decrements outstanding.
  - The PC comes from a response-PC counter that advances by 8 per accepted response.
  - In FLUSH, each response decrements discard and outstanding and is not written.
- Dequeue: inst_valid && inst_ready pops the head. Simultaneous push and pop keeps occupancy unchanged and must be correct at full and at empty (bypass rules below).
- Full: the credit rule guarantees a response always finds space. A response arriving at a full FIFO is a design error; flag it with a simulation assertion.
- Latency without bypass: from request issue to inst_valid is memory latency + 1 cycle; with the ram instance that is 2 cycles.
- Throughput: 1 word/cycle sustained when MAX_OUTSTANDING >= memory latency + 1.

Optional Feature:
- Macro: IFETCH_QUEUE_BYPASS_EN.
- Defined: when the FIFO is empty and a non-discarded response arrives, inst_valid/inst_data/inst_pc are driven combinationally from imem_data that cycle.
  - If inst_ready is high, the word is consumed without being written.
  - Otherwise it is written normally.
  - Saves 1 cycle of latency.
- Undefined: registered-only output; all outputs come from the FIFO head.

Test Plan:
- Reset release, inst_ready=1, ram latency 1: imem_addr sequence 0x0,0x8,0x10…; inst_pc 0x0 appears 2 cycles after the first request, then one word/cycle.
- inst_ready=0 with DEPTH=4: occupancy reaches 4 and imem_addr_valid stays 0. Then inst_ready=1: words drain in order with no duplicate or missing PC.
- Redirect to 0x1007 with 2 outstanding: state FLUSH, next 2 responses discarded. First request after that is to 0x1000; the first delivered inst_pc is 0x1000.
- Redirect asserted in the same cycle as pop and a response: FIFO empty next cycle, the response is dropped, no stale PC delivered.
- Redirect to 0xFFFF_FFFF_FFFF_FFF8: addresses wrap to 0x0 after the first word; inst_pc follows 0x…FF8 then 0x0.
- Bypass macro defined, empty queue, inst_ready=1: inst_pc valid in the same cycle as imem_data_valid. Macro undefined: valid one cycle later.

Source files
------------

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction prefetch FIFO between the fetch stage and imem.
// Define IFETCH_QUEUE_BYPASS_EN to forward an arriving word straight to an empty queue's output.
module ifetch_queue #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [63:0] RESET_PC        = 64'h0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect,
  input  logic [63:0]            redirect_pc,
  output logic [63:0]            imem_addr,
  output logic                   imem_addr_valid,
  input  logic [63:0]            imem_data,
  input  logic                   imem_data_valid,
  output logic [63:0]            inst_data,
  output logic [63:0]            inst_pc,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic {FETCH, FLUSH} state_t;

  state_t        state, state_next;
  logic [63:0]   fetch_pc, resp_pc, redirect_base;
  logic [CW-1:0] outstanding, out_after, discard, discard_next, count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [63:0]   data_mem [DEPTH];
  logic [63:0]   pc_mem   [DEPTH];

  logic resp_live, resp_keep, fifo_empty, fifo_full, bypass;
  logic issue, push, pop, pop_fifo;

  assign redirect_base = redirect_pc & ~64'h7;
  assign fifo_empty    = (count == '0);
  assign fifo_full     = (count == CW'(DEPTH));
  // A response with nothing outstanding is a leftover from before reset and is ignored.
  assign resp_live     = imem_data_valid && (outstanding != '0);
  assign resp_keep     = resp_live && (state == FETCH) && !redirect;
  assign out_after     = outstanding - (resp_live ? ONE : '0);

`ifdef IFETCH_QUEUE_BYPASS_EN
  assign bypass = fifo_empty && resp_keep;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    state_next   = state;
    discard_next = discard;
    issue        = 1'b0;
    case (state)
      FETCH: begin
        issue = (int'(count) + int'(outstanding) < DEPTH) &&
                (int'(outstanding) < MAX_OUTSTANDING) && !redirect;
      end
      FLUSH: begin
        if (resp_live) begin
          discard_next = discard - ONE;
        end
        // The last stale response frees the credit, so fetch restarts in the same cycle.
        if (resp_live && (discard == ONE)) begin
          state_next = FETCH;
          issue      = !redirect;
        end
      end
      default: state_next = FETCH;
    endcase
    if (redirect) begin
      discard_next = out_after;
      state_next   = (out_after != '0) ? FLUSH : FETCH;
    end
    if (rst) begin
      issue = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      discard     <= '0;
      outstanding <= '0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
    end else begin
      state       <= state_next;
      discard     <= discard_next;
      outstanding <= out_after + (issue ? ONE : '0);
      if (redirect) begin
        fetch_pc <= redirect_base;
      end else if (issue) begin
        fetch_pc <= fetch_pc + 64'd8;
      end
      if (redirect) begin
        resp_pc <= redirect_base;
      end else if (resp_keep) begin
        resp_pc <= resp_pc + 64'd8;
      end
    end
  end

  assign imem_addr       = fetch_pc;
  assign imem_addr_valid = issue;

  always_comb begin
    inst_valid = 1'b0;
    inst_data  = '0;
    inst_pc    = '0;
    if (!fifo_empty) begin
      inst_valid = 1'b1;
      inst_data  = data_mem[rd_ptr];
      inst_pc    = pc_mem[rd_ptr];
    end else if (bypass) begin
      inst_valid = 1'b1;
      inst_data  = imem_data;
      inst_pc    = resp_pc;
    end
  end

  assign pop       = inst_valid && inst_ready;
  assign pop_fifo  = pop && !fifo_empty;
  assign push      = resp_keep && !(bypass && inst_ready);
  assign occupancy = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_fifo) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop_fifo})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_data;
      pc_mem[wr_ptr]   <= resp_pc;
    end
  end

  // Credits guarantee space for every live response; arriving at a full queue means broken accounting.
  assert property (@(posedge clk) disable iff (rst) !(resp_keep && fifo_full));

endmodule

// File: tb/tb_ifetch_queue.sv
// Testbench for ifetch_queue: variable-latency in-order memory model plus a stream scoreboard.
module tb_ifetch_queue;

  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [63:0] RPC   = 64'h0;
`ifdef IFETCH_QUEUE_BYPASS_EN
  localparam int EXP_FIRST_VALID = 1;
`else
  localparam int EXP_FIRST_VALID = 2;
`endif

  logic                   clk;
  logic                   rst;
  logic                   redirect;
  logic [63:0]            redirect_pc;
  logic [63:0]            imem_addr;
  logic                   imem_addr_valid;
  logic [63:0]            imem_data;
  logic                   imem_data_valid;
  logic [63:0]            inst_data;
  logic [63:0]            inst_pc;
  logic                   inst_valid;
  logic                   inst_ready;
  logic [$clog2(DEPTH):0] occupancy;

  ifetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_addr_valid(imem_addr_valid),
    .imem_data(imem_data), .imem_data_valid(imem_data_valid),
    .inst_data(inst_data), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  logic [63:0] q_addr[$];
  int unsigned q_due[$];
  logic [63:0] exp_issue = RPC;
  logic [63:0] exp_deliver = RPC;
  logic [63:0] iss_log[$];
  logic [63:0] del_log[$];
  logic        s_addr_valid, s_inst_valid, s_dv;
  logic [63:0] s_addr;
  logic [$clog2(DEPTH):0] s_occ;

  // Memory contents are a bijection of the address, so a word tags its own origin.
  function automatic logic [63:0] word_of(input logic [63:0] a);
    return {a[31:0] ^ 32'hC0DE_F00D, ~a[63:32]};
  endfunction

  // One clock: memory answers, inputs are driven, outputs are scored against the stream model.
  task automatic step(input logic r, input logic redir, input logic [63:0] rpc,
                      input logic rdy, input logic spur);
    @(negedge clk);
    rst             = r;
    imem_data_valid = 1'b0;
    imem_data       = '0;
    if (spur) begin
      imem_data_valid = 1'b1;
      imem_data       = word_of(64'h5555_AAAA_0000_1230);
    end else if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      imem_data_valid = 1'b1;
      imem_data       = word_of(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end
    redirect    = redir;
    redirect_pc = rpc;
    inst_ready  = rdy;
    #1;
    s_addr_valid = imem_addr_valid;
    s_addr       = imem_addr;
    s_inst_valid = inst_valid;
    s_dv         = imem_data_valid;
    s_occ        = occupancy;
    if (r) begin
      exp_issue   = RPC;
      exp_deliver = RPC;
    end else begin
      if (redir) begin
        checks++;
        if (imem_addr_valid !== 1'b0)
          begin errors++; $display("[TB] FAIL issue_on_redirect: got %b expected 0", imem_addr_valid); end
      end
      if (imem_addr_valid) begin
        checks++;
        if (imem_addr !== exp_issue)
          begin errors++; $display("[TB] FAIL issue_addr: got %h expected %h", imem_addr, exp_issue); end
        iss_log.push_back(imem_addr);
        q_addr.push_back(imem_addr);
        q_due.push_back(cyc + $urandom_range(lat_max, lat_min));
        exp_issue += 64'd8;
        checks++;
        if (q_addr.size() > MAXO)
          begin errors++; $display("[TB] FAIL outstanding: got %0d expected <= %0d", q_addr.size(), MAXO); end
      end
      if (inst_valid && rdy) begin
        checks++;
        if (inst_pc !== exp_deliver || inst_data !== word_of(exp_deliver))
          begin errors++; $display("[TB] FAIL deliver: got pc %h data %h expected pc %h data %h",
                                   inst_pc, inst_data, exp_deliver, word_of(exp_deliver)); end
        del_log.push_back(inst_pc);
        exp_deliver += 64'd8;
      end
      checks++;
      if (int'(occupancy) > DEPTH)
        begin errors++; $display("[TB] FAIL occupancy_range: got %0d expected <= %0d", occupancy, DEPTH); end
      if (redir) begin
        exp_issue   = rpc & ~64'h7;
        exp_deliver = rpc & ~64'h7;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    repeat (6) step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    iss_log.delete();
    del_log.delete();
  endtask

  task automatic test_reset();
    lat_min = 1; lat_max = 1;
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    checks++; if (imem_addr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_addr_valid: got %b expected 0", imem_addr_valid); end
    checks++; if (imem_addr !== RPC) begin errors++; $display("[TB] FAIL rst_addr: got %h expected %h", imem_addr, RPC); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_inst_valid: got %b expected 0", inst_valid); end
    checks++; if (inst_data !== 64'h0) begin errors++; $display("[TB] FAIL rst_inst_data: got %h expected 0", inst_data); end
    checks++; if (inst_pc !== 64'h0) begin errors++; $display("[TB] FAIL rst_inst_pc: got %h expected 0", inst_pc); end
    checks++; if (occupancy !== '0) begin errors++; $display("[TB] FAIL rst_occupancy: got %0d expected 0", occupancy); end
  endtask

  task automatic test_startup();
    int   first_valid;
    logic v[12];
    lat_min = 1; lat_max = 1;
    do_reset();
    first_valid = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      v[i] = s_inst_valid;
      if (first_valid < 0 && s_inst_valid) first_valid = i;
    end
    checks++;
    if (first_valid != EXP_FIRST_VALID)
      begin errors++; $display("[TB] FAIL first_valid_cycle: got %0d expected %0d", first_valid, EXP_FIRST_VALID); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (iss_log.size() <= k || iss_log[k] !== RPC + 64'(8 * k))
        begin errors++; $display("[TB] FAIL startup_addr%0d: got %h expected %h", k,
                                 (iss_log.size() > k) ? iss_log[k] : 64'hX, RPC + 64'(8 * k)); end
    end
    for (int i = 2; i < 12; i++) begin
      checks++;
      if (v[i] !== 1'b1) begin errors++; $display("[TB] FAIL throughput_c%0d: got %b expected 1", i, v[i]); end
    end
    checks++;
    if (del_log.size() == 0 || del_log[0] !== RPC)
      begin errors++; $display("[TB] FAIL startup_first_pc: got %0d words expected first pc %h", del_log.size(), RPC); end
  endtask

  task automatic test_stall_full();
    lat_min = 1; lat_max = 1;
    do_reset();
    repeat (12) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    checks++; if (int'(s_occ) != DEPTH) begin errors++; $display("[TB] FAIL full_occupancy: got %0d expected %0d", s_occ, DEPTH); end
    checks++; if (s_addr_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_no_issue: got %b expected 0", s_addr_valid); end
    checks++; if (s_inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL full_valid: got %b expected 1", s_inst_valid); end
    repeat (10) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < DEPTH + 2; k++) begin
      checks++;
      if (del_log.size() <= k || del_log[k] !== RPC + 64'(8 * k))
        begin errors++; $display("[TB] FAIL drain_pc%0d: got %0d words expected pc %h", k, del_log.size(), RPC + 64'(8 * k)); end
    end
  endtask

  task automatic test_redirect_flush();
    int guard, nresp;
    logic issued;
    lat_min = 3; lat_max = 3;
    do_reset();
    guard = 0;
    while (q_addr.size() < 2 && guard < 10) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      guard++;
    end
    checks++;
    if (q_addr.size() != 2) begin errors++; $display("[TB] FAIL flush_setup: got %0d outstanding expected 2", q_addr.size()); end
    step(1'b0, 1'b1, 64'h1007, 1'b1, 1'b0);
    iss_log.delete();
    del_log.delete();
    nresp = 0;
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    if (s_dv) nresp++;
    checks++;
    if (s_addr_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_issue: got %b expected 0", s_addr_valid); end
    issued = s_addr_valid;
    guard  = 0;
    while (!issued && guard < 20) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      if (s_dv) nresp++;
      issued = s_addr_valid;
      guard++;
    end
    checks++;
    if (!issued || s_addr !== 64'h1000) begin errors++; $display("[TB] FAIL flush_restart_addr: got %h expected 1000", s_addr); end
    checks++;
    if (nresp != 2) begin errors++; $display("[TB] FAIL flush_discards: got %0d expected 2", nresp); end
    guard = 0;
    while (del_log.size() == 0 && guard < 20) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      guard++;
    end
    checks++;
    if (del_log.size() == 0 || del_log[0] !== 64'h1000)
      begin errors++; $display("[TB] FAIL flush_first_pc: got %0d words expected pc 1000", del_log.size()); end
  endtask

  task automatic test_redirect_pop_response();
    lat_min = 1; lat_max = 1;
    do_reset();
    repeat (6) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 64'h2000, 1'b1, 1'b0);
    checks++;
    if (s_dv !== 1'b1) begin errors++; $display("[TB] FAIL redir_resp_setup: got %b expected 1", s_dv); end
    del_log.delete();
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checks++; if (s_occ !== '0) begin errors++; $display("[TB] FAIL redir_empty: got %0d expected 0", s_occ); end
    checks++; if (s_inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_valid_low: got %b expected 0", s_inst_valid); end
    repeat (8) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (del_log.size() == 0 || del_log[0] !== 64'h2000)
      begin errors++; $display("[TB] FAIL redir_first_pc: got %0d words expected pc 2000", del_log.size()); end
  endtask

  task automatic test_wrap();
    lat_min = 1; lat_max = 2;
    do_reset();
    repeat (4) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b0);
    iss_log.delete();
    del_log.delete();
    repeat (14) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (iss_log.size() < 2 || iss_log[0] !== 64'hFFFF_FFFF_FFFF_FFF8 || iss_log[1] !== 64'h0)
      begin errors++; $display("[TB] FAIL wrap_addr: got %0d issues expected fff8 then 0", iss_log.size()); end
    checks++;
    if (del_log.size() < 2 || del_log[0] !== 64'hFFFF_FFFF_FFFF_FFF8 || del_log[1] !== 64'h0)
      begin errors++; $display("[TB] FAIL wrap_pc: got %0d words expected fff8 then 0", del_log.size()); end
  endtask

  task automatic test_reset_midflight();
    lat_min = 1; lat_max = 3;
    do_reset();
    repeat (8) step(1'b0, 1'b0, '0, 1'($urandom_range(1, 0)), 1'b0);
    repeat (6) step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    iss_log.delete();
    del_log.delete();
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    repeat (15) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (iss_log.size() == 0 || iss_log[0] !== RPC)
      begin errors++; $display("[TB] FAIL midrst_addr: got %0d issues expected first %h", iss_log.size(), RPC); end
    checks++;
    if (del_log.size() == 0 || del_log[0] !== RPC)
      begin errors++; $display("[TB] FAIL midrst_pc: got %0d words expected first %h", del_log.size(), RPC); end
  endtask

  task automatic test_random();
    logic        rd, rr;
    logic [63:0] tgt;
    lat_min = 1; lat_max = 3;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      rd  = ($urandom_range(3, 0) != 0);
      rr  = ($urandom_range(19, 0) == 0);
      tgt = ($urandom_range(1, 0) == 1) ? {$urandom, $urandom}
                                        : 64'hFFFF_FFFF_FFFF_FFE0 + 64'($urandom_range(31, 0));
      step(1'b0, rr, tgt, rd, 1'b0);
    end
    checks++;
    if (del_log.size() < 150) begin errors++; $display("[TB] FAIL random_progress: got %0d words expected >= 150", del_log.size()); end
  endtask

  initial begin
    rst             = 1'b1;
    redirect        = 1'b0;
    redirect_pc     = '0;
    imem_data       = '0;
    imem_data_valid = 1'b0;
    inst_ready      = 1'b0;
    test_reset();
    test_startup();
    test_stall_full();
    test_redirect_flush();
    test_redirect_pop_response();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
